// File: rtl/rom_burst_reader.sv
// Synchronous ROM with a burst read engine streaming consecutive words on valid/ready.
// Define ROM_WRAP_EN to accept bursts that run past the top address and wrap to 0.
module rom_burst_reader #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = "rom.hex"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W+1:0] DEPTH_EXT = (ADDR_W + 2)'(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   rom_word;
  logic                rd_en;
  logic                beat_xfer;
  logic                len_too_big;
  logic                wrap_reject;

  logic [DATA_W-1:0]   mem [DEPTH];

  // NOTE: the ROM image is set up once at time zero and is never reset;
  // only the control registers below see rst_n.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
  end

  assign rom_word = mem[rd_ptr_q];

  assign beat_xfer   = out_valid_q && out_ready;
  assign len_too_big = {1'b0, len} > DEPTH_EXT[ADDR_W+1:0];

`ifdef ROM_WRAP_EN
  // rd_ptr rolls over naturally, so running past the top is legal.
  assign wrap_reject = 1'b0;
`else
  logic [ADDR_W+1:0] end_addr;
  assign end_addr    = {2'b00, base_addr} + {1'b0, len};
  assign wrap_reject = end_addr > DEPTH_EXT;
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else if (len_too_big || wrap_reject) begin
            err_d = 1'b1;
          end else begin
            rd_ptr_d    = base_addr;
            remaining_d = len;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        // Abort wins over a beat handing over in the same cycle.
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          remaining_d = '0;
          state_d     = IDLE;
        end else begin
          rd_en = (remaining_q != '0) && (!out_valid_q || out_ready);
          if (rd_en) begin
            out_data_d  = rom_word;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == (ADDR_W + 1)'(1));
            rd_ptr_d    = rd_ptr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
          end else if (beat_xfer) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
          if (beat_xfer && out_last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: transaction-level model of expected beats plus directed cases.
// Honours ROM_WRAP_EN the same way as the design.
module tb_rom_burst_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 256;
`ifdef ROM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   len = '0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    beat_t      exp_q[$];
    logic [7:0] obs_data[$];
    logic       obs_last[$];
    int         obs_cyc[$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_err = 1'b0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         valid_cyc_cnt = 0;
    int         done_cyc = 0;

    rom_burst_reader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_FILE("")
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .len      (len),
        .abort    (abort),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected behaviour: a burst is a list of words (base+i) mod DEPTH, last flag on the
    // final one; each handshake consumes one; len=0 gives done, illegal requests give err.
    task automatic monitor();
        logic       p_stall;
        logic [7:0] p_data;
        logic       p_last;
        beat_t      b;
        beat_t      nb;
        int         l;
        int         ba;
        p_stall = 1'b0;
        p_data  = '0;
        p_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_done  = 1'b0;
                m_err   = 1'b0;
                p_stall = 1'b0;
                exp_q.delete();
                continue;
            end
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("err", err, m_err);
            check("done_err_excl", done & err, 0);
            if (!m_busy) check("valid_idle", out_valid, 0);
            if (p_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, p_data);
                check("stall_last", out_last, p_last);
            end
            if (m_busy && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    check("beat_data", out_data, exp_q[0].data);
                    check("beat_last", out_last, exp_q[0].last);
                end
            end
            if (out_valid) valid_cyc_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;

            m_done  = 1'b0;
            m_err   = 1'b0;
            p_stall = 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy = 1'b0;
                    exp_q.delete();
                end else if (out_valid && out_ready && exp_q.size() > 0) begin
                    b = exp_q.pop_front();
                    obs_data.push_back(out_data);
                    obs_last.push_back(out_last);
                    obs_cyc.push_back(cyc);
                    if (b.last) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end else if (out_valid && !out_ready) begin
                    p_stall = 1'b1;
                    p_data  = out_data;
                    p_last  = out_last;
                end
            end else if (start) begin
                l  = int'(len);
                ba = int'(base_addr);
                if (l == 0) m_done = 1'b1;
                else if (l > DEPTH) m_err = 1'b1;
                else if (ba + l > DEPTH && !WRAP_EN) m_err = 1'b1;
                else begin
                    m_busy = 1'b1;
                    for (int k = 0; k < l; k++) begin
                        nb.data = 8'((ba + k) % DEPTH);
                        nb.last = (k == l - 1);
                        exp_q.push_back(nb);
                    end
                end
            end
        end
    endtask

    task automatic issue(input logic [7:0] b, input logic [8:0] l);
        start     = 1'b1;
        base_addr = b;
        len       = l;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, (n < budget), 1);
        tick();
        tick();
    endtask

    task automatic stimulus();
        int         o0, d0, e0, v0, c0, n;
        bit         rp[4];
        logic [7:0] wrap_exp[4];
        rp       = '{1'b1, 1'b0, 1'b0, 1'b1};
        wrap_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        // Straight burst with no back-pressure.
        out_ready = 1'b1;
        o0 = obs_data.size(); d0 = done_cnt; c0 = cyc;
        issue(8'h00, 9'd17);
        run_until_idle("t1", 100);
        check("t1_beats", obs_data.size() - o0, 17);
        if (obs_data.size() - o0 == 17) begin
            check("t1_latency", obs_cyc[o0] - c0, 2);
            for (int i = 0; i < 17; i++) begin
                check("t1_data", obs_data[o0 + i], i);
                check("t1_last", obs_last[o0 + i], (i == 16));
                if (i > 0) check("t1_consec", obs_cyc[o0 + i] - obs_cyc[o0 + i - 1], 1);
            end
            check("t1_done_cyc", done_cyc - obs_cyc[o0 + 16], 1);
        end
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_busy_after", busy, 0);

        // Back-pressured burst.
        out_ready = 1'b0;
        o0 = obs_data.size(); d0 = done_cnt;
        issue(8'h05, 9'd4);
        n = 0;
        while (m_busy && n < 60) begin
            out_ready = rp[n % 4];
            tick();
            n++;
        end
        check("t2_timeout", (n < 60), 1);
        out_ready = 1'b1;
        tick(); tick();
        check("t2_beats", obs_data.size() - o0, 4);
        if (obs_data.size() - o0 == 4)
            for (int i = 0; i < 4; i++) begin
                check("t2_data", obs_data[o0 + i], 5 + i);
                check("t2_last", obs_last[o0 + i], (i == 3));
            end
        check("t2_done_cnt", done_cnt - d0, 1);

        // Burst crossing the top address.
        o0 = obs_data.size(); d0 = done_cnt; e0 = err_cnt; v0 = valid_cyc_cnt;
        issue(8'hFE, 9'd4);
`ifdef ROM_WRAP_EN
        run_until_idle("t3", 50);
        check("t3_beats", obs_data.size() - o0, 4);
        if (obs_data.size() - o0 == 4)
            for (int i = 0; i < 4; i++) check("t3_wrap_data", obs_data[o0 + i], wrap_exp[i]);
        check("t3_done_cnt", done_cnt - d0, 1);
        check("t3_err_cnt", err_cnt - e0, 0);
`else
        tick(); tick();
        check("t3_err_cnt", err_cnt - e0, 1);
        check("t3_valid_cycles", valid_cyc_cnt - v0, 0);
        check("t3_done_cnt", done_cnt - d0, 0);
        check("t3_wrap_unused", wrap_exp[0], 8'hFE);
`endif

        // Zero length and oversize length.
        o0 = obs_data.size(); d0 = done_cnt; e0 = err_cnt;
        issue(8'h33, 9'd0);
        tick(); tick();
        check("t4_len0_done", done_cnt - d0, 1);
        check("t4_len0_beats", obs_data.size() - o0, 0);
        check("t4_len0_err", err_cnt - e0, 0);
        d0 = done_cnt; e0 = err_cnt;
        issue(8'h00, 9'd257);
        tick(); tick();
        check("t4_len257_err", err_cnt - e0, 1);
        check("t4_len257_done", done_cnt - d0, 0);
        check("t4_len257_beats", obs_data.size() - o0, 0);

        // Start while busy is ignored.
        o0 = obs_data.size(); d0 = done_cnt; e0 = err_cnt;
        issue(8'h30, 9'd5);
        start = 1'b1; base_addr = 8'h80; len = 9'd3;
        tick(); tick(); tick();
        start = 1'b0;
        run_until_idle("t4b", 50);
        check("t4b_beats", obs_data.size() - o0, 5);
        if (obs_data.size() - o0 == 5)
            for (int i = 0; i < 5; i++) check("t4b_data", obs_data[o0 + i], 8'h30 + i);
        check("t4b_done", done_cnt - d0, 1);
        check("t4b_err", err_cnt - e0, 0);

        // Abort after the third beat, then a fresh burst.
        o0 = obs_data.size(); d0 = done_cnt; e0 = err_cnt;
        issue(8'h10, 9'd8);
        n = 0;
        while (obs_data.size() - o0 < 3 && n < 50) begin
            tick();
            n++;
        end
        check("t5_wait", (n < 50), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_valid_after_abort", out_valid, 0);
        check("t5_busy_after_abort", busy, 0);
        tick(); tick();
        check("t5_beats", obs_data.size() - o0, 3);
        if (obs_data.size() - o0 == 3)
            for (int i = 0; i < 3; i++) check("t5_data", obs_data[o0 + i], 8'h10 + i);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_no_err", err_cnt - e0, 0);
        o0 = obs_data.size(); d0 = done_cnt;
        issue(8'h20, 9'd2);
        run_until_idle("t5b", 50);
        check("t5b_beats", obs_data.size() - o0, 2);
        if (obs_data.size() - o0 == 2) begin
            check("t5b_data0", obs_data[o0], 8'h20);
            check("t5b_data1", obs_data[o0 + 1], 8'h21);
            check("t5b_last1", obs_last[o0 + 1], 1);
        end
        check("t5b_done", done_cnt - d0, 1);

        // Asynchronous reset mid-burst.
        o0 = obs_data.size();
        issue(8'h40, 9'd16);
        n = 0;
        while (obs_data.size() - o0 < 5 && n < 50) begin
            tick();
            n++;
        end
        check("t6_wait", (n < 50), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_last", out_last, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_beats_before", obs_data.size() - o0, 5);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        o0 = obs_data.size(); d0 = done_cnt;
        issue(8'h00, 9'd1);
        run_until_idle("t6b", 20);
        check("t6b_beats", obs_data.size() - o0, 1);
        if (obs_data.size() - o0 == 1) begin
            check("t6b_data", obs_data[o0], 8'h00);
            check("t6b_last", obs_last[o0], 1);
        end
        check("t6b_done", done_cnt - d0, 1);

        // Randomised traffic against the model.
        d0 = done_cnt;
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 5) == 0);
            base_addr = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       len = 9'd0;
                1:       len = 9'(257 + $urandom_range(0, 254));
                2:       len = 9'd256;
                default: len = 9'($urandom_range(1, 24));
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 59) == 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        run_until_idle("rand", 600);
        check("rand_activity", (done_cnt > d0), 1);
    endtask

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", out_data, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        fork
            monitor();
            stimulus();
            begin
                #1_000_000;
                n_total++;
                $display("FAIL watchdog: simulation time limit reached");
            end
        join_any
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
